// File: rtl/fpu_init_pkg.sv
// rtl/fpu_init_pkg.sv - shared types and constants for the FPU add/sub initiator
package fpu_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_ACK,
        ST_DRAIN,
        ST_RESP
    } state_t;

    localparam int FIFO_DEPTH  = 2;
    localparam int DRAIN_LIMIT = 4;
    localparam int DRAIN_CW    = $clog2(DRAIN_LIMIT);

endpackage

// File: rtl/fpu_req_fifo.sv
// rtl/fpu_req_fifo.sv - 2-entry request queue; push and pop may coincide, even when full
module fpu_req_fifo
    import fpu_init_pkg::*;
#(
    parameter int DW = 67
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_initiator.sv
// rtl/fpu_addsub_initiator.sv - queues add/sub requests, sequences the FPU handshake, returns responses
module fpu_addsub_initiator
    import fpu_init_pkg::*;
#(
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_x,
    input  logic [W-1:0] req_y,
    input  logic         req_op,
    input  logic [1:0]   req_rmode,
    output logic         fpu_beg,
    output logic         fpu_ack,
    output logic [W-1:0] fpu_data_x,
    output logic [W-1:0] fpu_data_y,
    output logic         fpu_add_subt,
    output logic [1:0]   fpu_r_mode,
    input  logic         fpu_ready,
    input  logic [W-1:0] fpu_result,
    input  logic         fpu_overflow,
    input  logic         fpu_underflow,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_overflow,
    output logic         rsp_underflow,
    output logic         rsp_timeout
);

    localparam int DW  = 2 * W + 3;
    localparam int TCW = $clog2(TIMEOUT);

    state_t              state_q, state_d;
    logic [TCW-1:0]      tcnt_q, tcnt_d;
    logic [DRAIN_CW-1:0] dcnt_q, dcnt_d;
    logic                ready_en_q;
    logic [W-1:0]        opx_q, opy_q;
    logic                op_q;
    logic [1:0]          rm_q;
    logic [W-1:0]        res_q;
    logic                ovf_q, unf_q, to_q;

    logic                fifo_full, fifo_empty, fifo_pop;
    logic [DW-1:0]       fifo_dout;
    logic [W-1:0]        f_x, f_y;
    logic                f_op;
    logic [1:0]          f_rm;
    logic                cap_fpu, cap_to;

    assign {f_op, f_rm, f_x, f_y} = fifo_dout;

    fpu_req_fifo #(.DW(DW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && req_ready),
        .din   ({req_op, req_rmode, req_x, req_y}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ready_en_q holds req_ready low until the first clock after reset release.
    assign req_ready     = ready_en_q && !fifo_full;
    assign fpu_beg       = (state_q == ST_START);
    assign fpu_ack       = (state_q == ST_ACK);
    assign rsp_valid     = (state_q == ST_RESP);
    assign fpu_data_x    = opx_q;
    assign fpu_data_y    = opy_q;
    assign fpu_add_subt  = op_q;
    assign fpu_r_mode    = rm_q;
    assign rsp_result    = res_q;
    assign rsp_overflow  = ovf_q;
    assign rsp_underflow = unf_q;
    assign rsp_timeout   = to_q;

    // The counter measures cycles since fpu_beg, so an abort acks TIMEOUT cycles after the start pulse.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        dcnt_d   = dcnt_q;
        fifo_pop = 1'b0;
        cap_fpu  = 1'b0;
        cap_to   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    tcnt_d   = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                tcnt_d  = tcnt_q + TCW'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_ready) begin
                    cap_fpu = 1'b1;
                    state_d = ST_ACK;
                end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
                    cap_to  = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
            ST_ACK: begin
                dcnt_d  = '0;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!fpu_ready || dcnt_q == DRAIN_CW'(DRAIN_LIMIT - 1)) begin
                    state_d = ST_RESP;
                end else begin
                    dcnt_d = dcnt_q + DRAIN_CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tcnt_q     <= '0;
            dcnt_q     <= '0;
            ready_en_q <= 1'b0;
            opx_q      <= '0;
            opy_q      <= '0;
            op_q       <= 1'b0;
            rm_q       <= 2'b00;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            dcnt_q     <= dcnt_d;
            ready_en_q <= 1'b1;
            if (fifo_pop) begin
                opx_q <= f_x;
                opy_q <= f_y;
                op_q  <= f_op;
                rm_q  <= f_rm;
            end
            if (cap_fpu) begin
                res_q <= fpu_result;
                ovf_q <= fpu_overflow;
                unf_q <= fpu_underflow;
                to_q  <= 1'b0;
            end else if (cap_to) begin
                res_q <= '0;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
                to_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_addsub_initiator.sv
// tb/tb_fpu_addsub_initiator.sv - bench for fpu_addsub_initiator with an FPU responder model
module tb_fpu_addsub_initiator;

    localparam int W  = 32;
    localparam int TO = 16;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        op;
        logic [1:0]  rm;
        logic        to;
    } req_t;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        to;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_x = '0, req_y = '0;
    logic         req_op = 1'b0;
    logic [1:0]   req_rmode = 2'b00;
    logic         fpu_beg, fpu_ack;
    logic [W-1:0] fpu_data_x, fpu_data_y;
    logic         fpu_add_subt;
    logic [1:0]   fpu_r_mode;
    logic         fpu_ready = 1'b0;
    logic [W-1:0] fpu_result = '0;
    logic         fpu_overflow = 1'b0, fpu_underflow = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic         rsp_overflow, rsp_underflow, rsp_timeout;

    fpu_addsub_initiator #(.W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_op(req_op), .req_rmode(req_rmode),
        .fpu_beg(fpu_beg), .fpu_ack(fpu_ack),
        .fpu_data_x(fpu_data_x), .fpu_data_y(fpu_data_y),
        .fpu_add_subt(fpu_add_subt), .fpu_r_mode(fpu_r_mode),
        .fpu_ready(fpu_ready), .fpu_result(fpu_result),
        .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .rsp_underflow(rsp_underflow), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    req_t exp_q[$];
    req_t cap_q[$];
    rsp_t obs_q[$];
    int   lat_q[$];

    int beg_cnt = 0, ack_cnt = 0, both_err = 0, stab_err = 0, rsp_stab_err = 0;
    int beg_cyc = 0, ack_cyc = 0, rsp_rise_cyc = 0, push_cyc = 0;
    int drop_fixed = 0;
    int rsp_mode = 1;

    bit          waiting = 0, dropping = 0, prev_valid = 0, prev_stall = 0;
    int          lat_left = 0, drop_left = 0;
    logic [31:0] cx = '0, cy = '0;
    logic        cop = 1'b0;
    logic [1:0]  crm = 2'b00;
    rsp_t        prev_rsp, cur_rsp, fres;
    req_t        capr;

    // Stand-in for the FPU arithmetic: known float cases, otherwise a fixed scramble with IEEE-style flags.
    function automatic rsp_t fpu_fn(logic [31:0] x, logic [31:0] y, logic op);
        rsp_t r;
        if (x == 32'h3F800000 && y == 32'h40000000 && !op)      r.res = 32'h40400000;
        else if (x == 32'h40400000 && y == 32'h3F800000 && op)  r.res = 32'h40000000;
        else if (x == 32'h7F000000 && y == 32'h7F000000 && !op) r.res = 32'h7F800000;
        else r.res = x ^ {y[15:0], y[31:16]} ^ {31'b0, op};
        r.ovf = (r.res[30:23] == 8'hFF);
        r.unf = (r.res[30:23] == 8'h00) && (r.res[22:0] != 23'h0);
        r.to  = 1'b0;
        return r;
    endfunction

    function automatic rsp_t exp_rsp(req_t q);
        rsp_t e;
        if (q.to) begin
            e = '0;
            e.to = 1'b1;
        end else begin
            e = fpu_fn(q.x, q.y, q.op);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            fpu_ready  = 1'b0;
            waiting    = 0;
            dropping   = 0;
            rsp_ready  = 1'b0;
            prev_valid = 0;
            prev_stall = 0;
        end else begin
            case (rsp_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
            cur_rsp = {rsp_result, rsp_overflow, rsp_underflow, rsp_timeout};
            if (rsp_valid && !prev_valid) rsp_rise_cyc = cyc;
            if (rsp_valid && prev_stall && cur_rsp != prev_rsp) rsp_stab_err++;
            if (rsp_valid && rsp_ready) obs_q.push_back(cur_rsp);
            prev_stall = rsp_valid && !rsp_ready;
            prev_valid = rsp_valid;
            prev_rsp   = cur_rsp;

            if (fpu_beg && fpu_ack) both_err++;
            if (fpu_beg) begin
                beg_cnt++;
                beg_cyc = cyc;
                cx = fpu_data_x; cy = fpu_data_y; cop = fpu_add_subt; crm = fpu_r_mode;
                capr = {cx, cy, cop, crm, 1'b0};
                cap_q.push_back(capr);
                lat_left = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                waiting = 1;
            end
            if (fpu_ack) begin
                ack_cnt++;
                ack_cyc = cyc;
                if (fpu_data_x !== cx || fpu_data_y !== cy || fpu_add_subt !== cop || fpu_r_mode !== crm)
                    stab_err++;
                waiting   = 0;
                dropping  = 1;
                drop_left = (drop_fixed >= 0) ? drop_fixed : int'($urandom_range(0, 2));
            end
            if (waiting && lat_left >= 0) begin
                if (lat_left == 0) begin
                    fres          = fpu_fn(cx, cy, cop);
                    fpu_result    = fres.res;
                    fpu_overflow  = fres.ovf;
                    fpu_underflow = fres.unf;
                    fpu_ready     = 1'b1;
                    waiting       = 0;
                end else begin
                    lat_left--;
                end
            end
            if (dropping) begin
                if (drop_left == 0) begin
                    fpu_ready = 1'b0;
                    dropping  = 0;
                end else begin
                    drop_left--;
                end
            end
        end
    end

    // lat < 0 means the FPU never answers; lat >= TO cannot beat the abort.
    task automatic send_req(input logic [31:0] x, input logic [31:0] y, input logic op,
                            input logic [1:0] rm, input int lat);
        req_t r;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_x = x; req_y = y; req_op = op; req_rmode = rm;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL send_req: req_ready=%0b after %0d cycles, required 1", req_ready, n);
            req_valid = 1'b0;
            return;
        end
        push_cyc = cyc;
        r = {x, y, op, rm, 1'((lat < 0) || (lat >= TO))};
        exp_q.push_back(r);
        lat_q.push_back(lat);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (obs_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (obs_q.size() < n) begin
            checks++; errors++;
            $display("FAIL wait_rsp: got %0d responses, required %0d", obs_q.size(), n);
        end
    endtask

    task automatic clear_q();
        exp_q.delete(); cap_q.delete(); obs_q.delete(); lat_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b, expected 0", req_ready); end
        checks++; if (fpu_beg !== 1'b0) begin errors++; $display("FAIL rst_fpu_beg: got %b, expected 0", fpu_beg); end
        checks++; if (fpu_ack !== 1'b0) begin errors++; $display("FAIL rst_fpu_ack: got %b, expected 0", fpu_ack); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b, expected 0", rsp_valid); end
        checks++; if (rsp_result !== '0) begin errors++; $display("FAIL rst_rsp_result: got %h, expected 0", rsp_result); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready: got %b, expected 0 before clock", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after_clk: got %b, expected 1", req_ready); end
    endtask

    task automatic test_add();
        int b0, a0;
        rsp_t o;
        clear_q(); rsp_mode = 1; drop_fixed = 0;
        b0 = beg_cnt; a0 = ack_cnt;
        send_req(32'h3F800000, 32'h40000000, 1'b0, 2'b01, 3);
        wait_rsp(1);
        repeat (3) @(negedge clk);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o.res !== 32'h40400000) begin errors++; $display("FAIL add_result: got %h, expected 40400000", o.res); end
            checks++; if ({o.ovf, o.unf, o.to} !== 3'b000) begin errors++; $display("FAIL add_flags: got %b, expected 000", {o.ovf, o.unf, o.to}); end
        end
        checks++; if (beg_cnt - b0 != 1) begin errors++; $display("FAIL add_beg_count: got %0d, expected 1", beg_cnt - b0); end
        checks++; if (ack_cnt - a0 != 1) begin errors++; $display("FAIL add_ack_count: got %0d, expected 1", ack_cnt - a0); end
        checks++; if (beg_cyc - push_cyc != 2) begin errors++; $display("FAIL add_beg_latency: got %0d, expected 2", beg_cyc - push_cyc); end
        checks++; if (ack_cyc - beg_cyc != 4) begin errors++; $display("FAIL add_ack_latency: got %0d, expected 4", ack_cyc - beg_cyc); end
    endtask

    task automatic test_sub();
        rsp_t o;
        req_t c;
        clear_q(); rsp_mode = 1; drop_fixed = 1;
        send_req(32'h40400000, 32'h3F800000, 1'b1, 2'b00, 0);
        wait_rsp(1);
        if (cap_q.size() > 0) begin
            c = cap_q.pop_front();
            checks++; if (c.op !== 1'b1) begin errors++; $display("FAIL sub_add_subt: got %b, expected 1", c.op); end
            checks++; if (c.rm !== 2'b00) begin errors++; $display("FAIL sub_r_mode: got %b, expected 00", c.rm); end
            checks++; if (c.x !== 32'h40400000 || c.y !== 32'h3F800000) begin errors++; $display("FAIL sub_operands: got %h %h, expected 40400000 3f800000", c.x, c.y); end
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o.res !== 32'h40000000) begin errors++; $display("FAIL sub_result: got %h, expected 40000000", o.res); end
        end
    endtask

    task automatic test_overflow();
        rsp_t o;
        clear_q(); rsp_mode = 1; drop_fixed = 0;
        send_req(32'h7F000000, 32'h7F000000, 1'b0, 2'b11, 2);
        wait_rsp(1);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o.res !== 32'h7F800000) begin errors++; $display("FAIL ovf_result: got %h, expected 7f800000", o.res); end
            checks++; if ({o.ovf, o.unf, o.to} !== 3'b100) begin errors++; $display("FAIL ovf_flags: got %b, expected 100", {o.ovf, o.unf, o.to}); end
        end
    endtask

    task automatic test_timeout();
        int lats[3];
        rsp_t o;
        lats[0] = -1; lats[1] = 15; lats[2] = 16;
        rsp_mode = 1; drop_fixed = 0;
        for (int i = 0; i < 3; i++) begin
            clear_q();
            send_req(32'h3F800000 + i, 32'h00ABCDEF, 1'b0, 2'b10, lats[i]);
            wait_rsp(1);
            checks++; if (ack_cyc - beg_cyc != TO) begin errors++; $display("FAIL timeout_ack_lat[%0d]: got %0d, expected %0d", i, ack_cyc - beg_cyc, TO); end
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                checks++; if (o !== exp_rsp(exp_q[0])) begin errors++; $display("FAIL timeout_rsp[%0d]: got %h, expected %h", i, o, exp_rsp(exp_q[0])); end
                if (lats[i] < 0) begin
                    checks++; if (o.to !== 1'b1 || o.res !== '0) begin errors++; $display("FAIL timeout_flag: got to=%b res=%h, expected to=1 res=0", o.to, o.res); end
                end
            end
        end
    endtask

    task automatic test_drain();
        int drops[3], want[3];
        drops[0] = 0; drops[1] = 3; drops[2] = 6;
        want[0]  = 2; want[1]  = 4; want[2]  = 5;
        rsp_mode = 1;
        for (int i = 0; i < 3; i++) begin
            clear_q();
            drop_fixed = drops[i];
            send_req(32'h11110000 + i, 32'h22220000, 1'b0, 2'b00, 1);
            wait_rsp(1);
            checks++; if (rsp_rise_cyc - ack_cyc != want[i]) begin errors++; $display("FAIL drain_lat[drop=%0d]: got %0d, expected %0d", drops[i], rsp_rise_cyc - ack_cyc, want[i]); end
            repeat (8) @(negedge clk);
        end
        drop_fixed = 0;
    endtask

    task automatic test_back_to_back();
        int b0, p1;
        rsp_t o;
        clear_q(); rsp_mode = 0; drop_fixed = 0;
        b0 = beg_cnt;
        send_req(32'h3F800000, 32'h40000000, 1'b0, 2'b00, 1);
        p1 = push_cyc;
        send_req(32'hA5A50001, 32'h5A5A0002, 1'b1, 2'b01, 1);
        send_req(32'hC0000003, 32'h00000004, 1'b0, 2'b10, 1);
        checks++; if (push_cyc - p1 != 2) begin errors++; $display("FAIL b2b_accept_span: got %0d, expected 2", push_cyc - p1); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_3: got %b, expected 0", req_ready); end
        repeat (20) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held: got %b, expected 0", req_ready); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_no_rsp: got %0d, expected 0", obs_q.size()); end
        checks++; if (beg_cnt - b0 != 1) begin errors++; $display("FAIL b2b_in_flight: got %0d, expected 1", beg_cnt - b0); end
        rsp_mode = 1;
        send_req(32'h7F000000, 32'h7F000000, 1'b0, 2'b11, 1);
        wait_rsp(4);
        for (int i = 0; i < 4; i++) begin
            if (obs_q.size() > 0 && exp_q.size() > 0) begin
                o = obs_q.pop_front();
                checks++; if (o !== exp_rsp(exp_q[0])) begin errors++; $display("FAIL b2b_rsp[%0d]: got %h, expected %h", i, o, exp_rsp(exp_q[0])); end
                exp_q.delete(0);
            end
        end
    endtask

    task automatic test_random();
        int b0, a0, lat, n;
        rsp_t o;
        req_t c;
        clear_q(); rsp_mode = 2; drop_fixed = -1;
        b0 = beg_cnt; a0 = ack_cnt;
        n = 40;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            lat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 5));
            send_req($urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), lat);
        end
        wait_rsp(n);
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (obs_q.size() > 0 && exp_q.size() > 0 && cap_q.size() > 0) begin
                o = obs_q.pop_front();
                c = cap_q.pop_front();
                checks++; if (o !== exp_rsp(exp_q[0])) begin errors++; $display("FAIL rand_rsp[%0d]: got %h, expected %h", i, o, exp_rsp(exp_q[0])); end
                checks++; if (c[66:1] !== exp_q[0][66:1]) begin errors++; $display("FAIL rand_fpu_inputs[%0d]: got %h, expected %h", i, c[66:1], exp_q[0][66:1]); end
                exp_q.delete(0);
            end
        end
        checks++; if (beg_cnt - b0 != n || ack_cnt - a0 != n) begin errors++; $display("FAIL rand_pulses: got beg=%0d ack=%0d, expected %0d each", beg_cnt - b0, ack_cnt - a0, n); end
        checks++; if (both_err != 0) begin errors++; $display("FAIL beg_ack_overlap: got %0d, expected 0", both_err); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL fpu_operand_stability: got %0d, expected 0", stab_err); end
        checks++; if (rsp_stab_err != 0) begin errors++; $display("FAIL rsp_payload_stability: got %0d, expected 0", rsp_stab_err); end
        rsp_mode = 1; drop_fixed = 0;
    endtask

    task automatic test_reset_mid();
        int b0, k;
        rsp_t o;
        clear_q(); rsp_mode = 1; drop_fixed = 0;
        b0 = beg_cnt;
        send_req(32'h12345678, 32'h9ABCDEF0, 1'b1, 2'b11, -1);
        k = 0;
        while (beg_cnt == b0 && k < 50) begin @(negedge clk); k++; end
        send_req(32'h0BADF00D, 32'h00C0FFEE, 1'b0, 2'b01, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (fpu_data_x !== '0 || fpu_add_subt !== 1'b0) begin errors++; $display("FAIL midrst_operands: got %h/%b, expected 0/0", fpu_data_x, fpu_add_subt); end
        checks++; if ({req_ready, fpu_beg, fpu_ack, rsp_valid} !== 4'b0000) begin errors++; $display("FAIL midrst_ctrl: got %b, expected 0000", {req_ready, fpu_beg, fpu_ack, rsp_valid}); end
        repeat (2) @(negedge clk);
        clear_q();
        rst = 1'b0;
        b0 = beg_cnt;
        repeat (30) @(negedge clk);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_no_rsp: got %0d, expected 0", obs_q.size()); end
        checks++; if (beg_cnt != b0) begin errors++; $display("FAIL midrst_no_beg: got %0d, expected 0", beg_cnt - b0); end
        send_req(32'h3F800000, 32'h40000000, 1'b0, 2'b00, 2);
        wait_rsp(1);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o !== 35'({32'h40400000, 3'b000})) begin errors++; $display("FAIL midrst_new_rsp: got %h, expected %h", o, 35'({32'h40400000, 3'b000})); end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_timeout();
        test_drain();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
